// File: rtl/alu_share_if.sv
// Request/response/ALU signal bundle between the shared-ALU arbiter and its clients.
// The slave modport is the arbiter side; master is the client/ALU side.
interface alu_share_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FUN_W  = 4;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [FUN_W-1:0]  req0_fun;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [FUN_W-1:0]  req1_fun;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_err;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [FUN_W-1:0]  alu_fun;
    logic [DATA_W-1:0] alu_out;
    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fun,
        input  req1_valid, req1_a, req1_b, req1_fun,
        input  rsp0_ready, rsp1_ready, alu_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_err, alu_a, alu_b, alu_fun, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_fun,
        output req1_valid, req1_a, req1_b, req1_fun,
        output rsp0_ready, rsp1_ready, alu_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_err, alu_a, alu_b, alu_fun, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer granting one shared 32-bit ALU to two requesters,
// with registered ALU operands and a per-requester valid/ready response.
module alu_share_arbiter #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_share_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FUN_W  = 4;
    localparam logic [FUN_W-1:0] FUN_PASS_A = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              prio;
    logic              owner;
    logic              legal;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [FUN_W-1:0]  alu_fun_q;
    logic [DATA_W-1:0] result_q;
    logic              err_q;

    logic              grant0_c;
    logic              grant1_c;
    logic              rsp_done_c;
    logic [DATA_W-1:0] sel_a_c;
    logic [DATA_W-1:0] sel_b_c;
    logic [FUN_W-1:0]  sel_fun_c;
    logic              sel_legal_c;

    function automatic logic fun_is_legal(input logic [FUN_W-1:0] f);
        case (f)
            4'b0000, 4'b1000, 4'b0110, 4'b0111, 4'b0100, 4'b0101,
            4'b0001, 4'b1101, 4'b0010, 4'b0011, 4'b1001: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Winner selection in IDLE; priority pointer breaks ties.
    always_comb begin
        state_d    = state;
        grant0_c   = 1'b0;
        grant1_c   = 1'b0;
        rsp_done_c = 1'b0;
        case (state)
            IDLE: begin
                grant0_c = bus.req0_valid && !(bus.req1_valid && prio);
                grant1_c = bus.req1_valid && !(bus.req0_valid && !prio);
                if (grant0_c || grant1_c) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_done_c = owner ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_done_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_a_c     = grant1_c ? bus.req1_a   : bus.req0_a;
    assign sel_b_c     = grant1_c ? bus.req1_b   : bus.req0_b;
    assign sel_fun_c   = grant1_c ? bus.req1_fun : bus.req0_fun;
    assign sel_legal_c = fun_is_legal(sel_fun_c);

    // Operand capture on grant, result capture in EXEC, pointer flip on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= RESET_PRIO;
            owner     <= 1'b0;
            legal     <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_fun_q <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (grant0_c || grant1_c) begin
                alu_a_q   <= sel_a_c;
                alu_b_q   <= sel_b_c;
                alu_fun_q <= sel_legal_c ? sel_fun_c : FUN_PASS_A;
                owner     <= grant1_c;
                legal     <= sel_legal_c;
            end
            if (state == EXEC) begin
                result_q <= legal ? bus.alu_out : '0;
                err_q    <= !legal;
            end
            if (rsp_done_c) prio <= !owner;
        end
    end

    assign bus.req0_ready = grant0_c;
    assign bus.req1_ready = grant1_c;
    assign bus.rsp0_valid = (state == RESP) && !owner;
    assign bus.rsp1_valid = (state == RESP) && owner;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_fun    = alu_fun_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a transaction-level
// model; a behavioural ALU closes the loop on alu_out.
module tb_alu_share_arbiter;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_share_if bus ();

    alu_share_arbiter #(.RESET_PRIO(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        case (f)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return 32'($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a;
        endcase
    endfunction

    function automatic logic fun_legal(input logic [3:0] f);
        logic [15:0] mask;
        mask = 16'h23FF;
        return mask[f];
    endfunction

    function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] f);
        return fun_legal(f) ? alu_ref(a, b, f) : 32'd0;
    endfunction

    assign bus.alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_fun);

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_fun = f;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_fun = f;
        end
    endtask

    task automatic idle_inputs();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk1({tag, "_req0_ready"}, bus.req0_ready, 1'b0);
        chk1({tag, "_req1_ready"}, bus.req1_ready, 1'b0);
        chk1({tag, "_rsp0_valid"}, bus.rsp0_valid, 1'b0);
        chk1({tag, "_rsp1_valid"}, bus.rsp1_valid, 1'b0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        chk32({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
        chk32({tag, "_alu_a"}, bus.alu_a, 32'd0);
        chk32({tag, "_alu_b"}, bus.alu_b, 32'd0);
        chk32({tag, "_alu_fun"}, 32'(bus.alu_fun), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        #1 chk_outputs_zero(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated operation with response ready already high; checks 2-cycle latency.
    task automatic do_op(input string tag, input int id, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] f,
                         input logic [31:0] res, input logic err, input logic [3:0] alu_f);
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b, f);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        chk1({tag, "_grant"}, (id == 0) ? bus.req0_ready : bus.req1_ready, 1'b1);
        chk1({tag, "_other_ready"}, (id == 0) ? bus.req1_ready : bus.req0_ready, 1'b0);
        @(posedge clk); #1;
        set_req(id, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk1({tag, "_exec_busy"}, bus.busy, 1'b1);
        chk1({tag, "_exec_no_rsp"}, bus.rsp0_valid | bus.rsp1_valid, 1'b0);
        chk32({tag, "_exec_alu_fun"}, 32'(bus.alu_fun), 32'(alu_f));
        chk32({tag, "_exec_alu_a"}, bus.alu_a, a);
        @(negedge clk);
        chk1({tag, "_rsp_valid"}, (id == 0) ? bus.rsp0_valid : bus.rsp1_valid, 1'b1);
        chk1({tag, "_rsp_other"}, (id == 0) ? bus.rsp1_valid : bus.rsp0_valid, 1'b0);
        chk32({tag, "_result"}, bus.rsp_result, res);
        chk1({tag, "_err"}, bus.rsp_err, err);
        @(posedge clk); #1;
        @(negedge clk);
        chk1({tag, "_done_idle"}, bus.busy, 1'b0);
    endtask

    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [3:0]  pf [2];
    logic        pend [2];
    logic        inflight, mowner, mprio, merr, g;
    logic        e_rdy0, e_rdy1, e_rsp0, e_rsp1;
    logic [31:0] mres;
    int          age;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        do_reset("reset");

        do_op("add", 0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0, 4'b0000);

        // Contention: both requesters hold valid, round-robin from priority 0.
        do_reset("reset2");
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h10, 32'h01, 4'b0000);
        set_req(1, 1'b1, 32'h20, 32'h01, 4'b1000);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk1("cont_ready0", bus.req0_ready, (c == 0) || (c == 6));
            chk1("cont_ready1", bus.req1_ready, c == 3);
            if (c == 2 || c == 8) begin
                chk1("cont_rsp0", bus.rsp0_valid, 1'b1);
                chk32("cont_res0", bus.rsp_result, 32'h11);
            end
            if (c == 5) begin
                chk1("cont_rsp1", bus.rsp1_valid, 1'b1);
                chk32("cont_res1", bus.rsp_result, 32'h1F);
            end
        end
        @(posedge clk); #1;
        idle_inputs();

        // Backpressure on requester 1 while requester 0 waits.
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'h0F, 32'hF0, 4'b0110);
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk1("bp_grant1", bus.req1_ready, 1'b1);
        chk1("bp_no_grant0", bus.req0_ready, 1'b0);
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(0, 1'b1, 32'd1, 32'd2, 4'b0000);
        @(negedge clk);
        chk1("bp_exec_ready0", bus.req0_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("bp_rsp1_valid", bus.rsp1_valid, 1'b1);
            chk1("bp_rsp0_valid", bus.rsp0_valid, 1'b0);
            chk32("bp_result", bus.rsp_result, 32'hFF);
            chk1("bp_ready0", bus.req0_ready, 1'b0);
            chk1("bp_busy", bus.busy, 1'b1);
        end
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_valid", bus.rsp1_valid, 1'b1);
        chk1("bp_release_ready0", bus.req0_ready, 1'b0);
        @(negedge clk);
        chk1("bp_after_ready0", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chk1("bp_rsp0_valid2", bus.rsp0_valid, 1'b1);
        chk32("bp_result2", bus.rsp_result, 32'd3);
        @(posedge clk); #1;
        idle_inputs();

        do_op("illegal", 0, 32'd7, 32'd9, 4'b1111, 32'd0, 1'b1, 4'b1001);
        do_op("sra", 1, 32'h8000_0000, 32'd4, 4'b1101, 32'hF800_0000, 1'b0, 4'b1101);
        do_op("slt", 0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, 1'b0, 4'b0010);

        // Reset pulsed during EXEC discards the operation.
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'd100, 32'd1, 4'b0000);
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk1("mid_grant", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk1("mid_exec_busy", bus.busy, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_outputs_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("mid_no_rsp", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
            chk1("mid_idle", bus.busy, 1'b0);
        end
        do_op("post_rst_add", 0, 32'd2, 32'd2, 4'b0000, 32'd4, 1'b0, 4'b0000);

        // Random traffic against a transaction-level model.
        do_reset("reset3");
        mprio = 1'b0;
        inflight = 1'b0;
        mowner = 1'b0;
        merr = 1'b0;
        mres = '0;
        age = 0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; pa[r] = '0; pb[r] = '0; pf[r] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if (!pend[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[r] = 1'b1;
                        pa[r] = $urandom;
                        pb[r] = $urandom;
                        pf[r] = 4'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[r] = 1'b0;
                end
                set_req(r, pend[r], pa[r], pb[r], pf[r]);
            end
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_rdy0 = !inflight && pend[0] && !(pend[1] && mprio);
            e_rdy1 = !inflight && pend[1] && !(pend[0] && !mprio);
            e_rsp0 = inflight && (age >= 2) && !mowner;
            e_rsp1 = inflight && (age >= 2) && mowner;
            chk1("rnd_ready0", bus.req0_ready, e_rdy0);
            chk1("rnd_ready1", bus.req1_ready, e_rdy1);
            chk1("rnd_rsp0", bus.rsp0_valid, e_rsp0);
            chk1("rnd_rsp1", bus.rsp1_valid, e_rsp1);
            chk1("rnd_busy", bus.busy, inflight);
            if (e_rsp0 || e_rsp1) begin
                chk32("rnd_result", bus.rsp_result, mres);
                chk1("rnd_err", bus.rsp_err, merr);
            end
            if (inflight) begin
                if ((e_rsp0 && bus.rsp0_ready) || (e_rsp1 && bus.rsp1_ready)) begin
                    inflight = 1'b0;
                    mprio = !mowner;
                end else begin
                    age++;
                end
            end else if (e_rdy0 || e_rdy1) begin
                g = e_rdy1;
                inflight = 1'b1;
                age = 1;
                mowner = g;
                mres = exp_result(pa[g], pb[g], pf[g]);
                merr = !fun_legal(pf[g]);
                pend[g] = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU. It accepts operations from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It drives registered operands and function code into the ALU, captures the ALU result, and returns it to the owning requester with its own valid/ready response handshake. It sits between the ALU and its clients, for example the execute stage and an address-generation unit.

## Interface
- RESET_PRIO, 0: requester (0 or 1) that holds priority after reset.

- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- REQ0_VALID / REQ1_VALID  in  1  request valid, per requester.
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle.
- REQ0_A / REQ1_A  in  32  operand A.
- REQ0_B / REQ1_B  in  32  operand B.
- REQ0_FUN / REQ1_FUN  in  4  ALU function code.
- RSP0_VALID / RSP1_VALID  out  1  response valid, per requester.
- RSP0_READY / RSP1_READY  in  1  response accepted.
- RSP_RESULT  out  32  shared result register.
- RSP_ERR  out  1  shared; set when the function code was illegal.
- ALU_A, ALU_B  out  32  registered operands to the ALU.
- ALU_FUN  out  4  registered function code to the ALU.
- ALU_OUT  in  32  combinational ALU result.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, winner selection:
  - If only one REQx_VALID is high, that requester wins.
  - If both are high, the requester equal to the priority pointer PRIO wins.
  - REQx_READY = (state==IDLE) && winner==x, combinational. At most one READY is high per cycle.
- IDLE, on handshake (VALID && READY):
  - Latch A, B, FUN into ALU_A/ALU_B/ALU_FUN.
  - Latch owner id and the legal flag.
  - Go to EXEC.
- EXEC (exactly one cycle):
  - RSP_RESULT <= legal ? ALU_OUT : 0.
  - RSP_ERR <= !legal.
  - Go to RESP.
- RESP:
  - RSPowner_VALID is high; the other RSP valid is low.
  - RSP_RESULT and RSP_ERR are held stable.
  - On RSPowner_READY: go to IDLE and set PRIO <= ~owner.
- Legal codes: 0000, 1000, 0110, 0111, 0100, 0101, 0001, 1101, 0010, 0011, 1001.
- Illegal codes:
  - ALU_FUN is driven as 1001 (pass-through A) so the ALU never sees an undecoded code.
  - Result is forced to 0 and RSP_ERR=1.
- Requesters must hold VALID, A, B and FUN stable until READY. The arbiter samples them only in the handshake cycle.
- A VALID that drops without a handshake is permitted and is ignored.
- A requester may present a new request while its response is pending. It is not granted until the FSM returns to IDLE.

## Timing
- Reset values (async, immediate on RST_N low):
  - state=IDLE, PRIO=RESET_PRIO.
  - ALU_A=ALU_B=0, ALU_FUN=0000.
  - RSP_RESULT=0, RSP_ERR=0.
  - All READY/RSP_VALID=0, BUSY=0.
- Latency: handshake at edge N, EXEC during cycle N+1, RSPx_VALID high from cycle N+2.
- Minimum occupancy is 3 cycles per operation (RESP with READY already high, then IDLE). Peak throughput is one op per 3 cycles.
- RESP backpressure has no bound. The FSM holds indefinitely and both REQ_READY lines stay 0.
- Simultaneous requests with PRIO=0 are served in order 0, 1, 0, 1... Neither requester is starved while both stay asserted.
- PRIO updates only on response completion, never on request-only cycles.
- Reset mid-operation (EXEC or RESP):
  - The operation is discarded and no response is issued.
  - All outputs return to reset values asynchronously.
  - The first edge after RST_N rises is IDLE with PRIO=RESET_PRIO.
- Width rules:
  - All data is 32-bit.
  - The arbiter does no arithmetic on data; the result is ALU_OUT truncated/forwarded unchanged.

## Test plan
- Single add:
  - Stimulus: REQ0 A=5, B=3, FUN=0000; RSP0_READY tied high.
  - Required: REQ0_READY=1 at cycle 0; RSP0_VALID=1 at cycle 2 with RSP_RESULT=8, RSP_ERR=0; RSP1_VALID stays 0.
- Contention, RESET_PRIO=0:
  - Stimulus: both requesters hold VALID continuously. REQ0 sends 0x10+0x01; REQ1 sends 0x20-0x01 (FUN=1000).
  - Required: order is REQ0 (0x11), then REQ1 (0x1F), then REQ0 again; grants spaced 3 cycles apart.
- Backpressure:
  - Stimulus: REQ1 A=0x0F, B=0xF0, FUN=0110; RSP1_READY low for 4 cycles; REQ0_VALID high throughout.
  - Required: RSP1_VALID and RSP_RESULT=0xFF stable for all 4 cycles; REQ0_READY=0 and BUSY=1 until RSP1_READY is asserted.
- Illegal code:
  - Stimulus: FUN=1111, A=7, B=9.
  - Required: ALU_FUN=1001 during EXEC; response RSP_RESULT=0, RSP_ERR=1.
- Arithmetic shift:
  - Stimulus: A=0x80000000, B=4, FUN=1101.
  - Required: RSP_RESULT=0xF8000000. Then SLT with A=0xFFFFFFFF, B=1, FUN=0010 gives 1.
- Reset mid-operation:
  - Stimulus: RST_N pulsed low during EXEC.
  - Required: all outputs are 0 immediately and no RSP_VALID appears; a following REQ0 add 2+2 returns 4 with normal 2-cycle latency.
